// File: rtl/gr_heep_pkg.sv
// GR-HEEP shared limits and types for the OBI memory responder.
// Pure type definitions: no latency and no flow control of their own.
package gr_heep_pkg;

  localparam int unsigned ObiMemSlaveMaxWait = 15;
  localparam int unsigned ObiMemSlaveMaxLat  = 8;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
  } obi_mem_resp_slot_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } obi_mem_gnt_state_e;

endpackage

// File: rtl/obi_pkg.sv
// OBI request/response bundles shared by masters and responders on the external crossbar.
// Pure type definitions: no latency and no flow control of their own.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/gr_heep_obi_resp_delay.sv
// Fixed-latency response pipe: LATENCY register stages; only the valid bits are reset.
// No backpressure: one slot enters and one leaves every cycle.
module gr_heep_obi_resp_delay
  import gr_heep_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  obi_mem_resp_slot_t i_slot,
  output obi_mem_resp_slot_t o_slot
);

  logic [LATENCY-1:0] r_valid;
  logic [31:0]        r_rdata [LATENCY];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else begin
      r_valid[0] <= i_slot.valid;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  // Data stages carry no reset; the valid bit qualifies them downstream.
  always_ff @(posedge i_clk) begin
    r_rdata[0] <= i_slot.rdata;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      r_rdata[i] <= r_rdata[i-1];
    end
  end

  assign o_slot.valid = r_valid[LATENCY-1];
  assign o_slot.rdata = r_rdata[LATENCY-1];

endmodule

// File: rtl/gr_heep_obi_mem_slave.sv
// OBI word memory responder: GNT_WAIT grant wait states, rvalid RESP_LATENCY cycles after grant.
// No rready; responses are never stalled and leave in grant order.
module gr_heep_obi_mem_slave
  import obi_pkg::*;
  import gr_heep_pkg::*;
#(
  parameter int unsigned NUM_WORDS    = 1024,
  parameter int unsigned GNT_WAIT     = 0,
  parameter int unsigned RESP_LATENCY = 1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  obi_req_t  slave_req_i,
  output obi_resp_t slave_resp_o
);

  localparam int unsigned AddrW      = $clog2(NUM_WORDS);
  localparam logic [3:0]  GntWaitCnt = 4'(GNT_WAIT);

  if (NUM_WORDS < 2 || (NUM_WORDS & (NUM_WORDS - 1)) != 0) begin : g_bad_num_words
    $error("NUM_WORDS must be a power of two and at least 2");
  end
  if (GNT_WAIT > ObiMemSlaveMaxWait) begin : g_bad_gnt_wait
    $error("GNT_WAIT out of range 0..15");
  end
  if (RESP_LATENCY < 1 || RESP_LATENCY > ObiMemSlaveMaxLat) begin : g_bad_resp_latency
    $error("RESP_LATENCY out of range 1..8");
  end

  obi_mem_gnt_state_e r_state, w_state_nxt;
  logic [3:0]         r_cnt, w_cnt_nxt;
  logic               w_gnt;
  logic               w_xfer;
  logic [AddrW-1:0]   w_idx;
  logic [31:0]        w_rdata;
  logic               w_unused_addr;
  obi_mem_resp_slot_t w_slot_in, w_slot_out;

  logic [31:0] r_mem [NUM_WORDS];

  assign w_idx         = slave_req_i.addr[AddrW+1:2];
  assign w_unused_addr = ^{slave_req_i.addr[31:AddrW+2], slave_req_i.addr[1:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gnt       = 1'b0;
    case (r_state)
      IDLE: begin
        if (GNT_WAIT == 0) begin
          w_gnt = slave_req_i.req;
        end else if (slave_req_i.req) begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = 4'd1;
        end
      end
      WAIT: begin
        // A withdrawn request is abandoned silently; the next one waits in full.
        if (!slave_req_i.req) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == GntWaitCnt) begin
          w_gnt       = 1'b1;
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_xfer = slave_req_i.req & w_gnt;

  always_ff @(posedge clk_i) begin
    if (w_xfer && slave_req_i.we) begin
      for (int k = 0; k < 4; k++) begin
        if (slave_req_i.be[k]) begin
          r_mem[w_idx][8*k +: 8] <= slave_req_i.wdata[8*k +: 8];
        end
      end
    end
  end

  // Read data is sampled at the grant edge, so it sees a write granted the cycle before.
  assign w_rdata         = r_mem[w_idx];
  assign w_slot_in.valid = w_xfer;
  assign w_slot_in.rdata = (w_xfer && !slave_req_i.we) ? w_rdata : 32'h0;

  gr_heep_obi_resp_delay #(
    .LATENCY (RESP_LATENCY)
  ) u_resp_delay (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_slot  (w_slot_in),
    .o_slot  (w_slot_out)
  );

  assign slave_resp_o.gnt    = w_gnt;
  assign slave_resp_o.rvalid = w_slot_out.valid;
  assign slave_resp_o.rdata  = w_slot_out.valid ? w_slot_out.rdata : 32'h0;

  a_req_stable : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (slave_req_i.req && !w_gnt) |=>
      (!slave_req_i.req || ($stable(slave_req_i.addr) && $stable(slave_req_i.we) &&
                            $stable(slave_req_i.be) && $stable(slave_req_i.wdata)))
  );

endmodule

// File: tb/tb_gr_heep_obi_mem_slave.sv
// Bench for gr_heep_obi_mem_slave: three parameterisations against a transaction-level model.
module tb_gr_heep_obi_mem_slave;
  import obi_pkg::*;

  typedef struct {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } stim_t;

  typedef struct {
    int          d;
    int          due;
    logic [31:0] data;
  } exp_t;

  logic      clk   = 1'b0;
  logic      rst_n = 1'b0;
  obi_req_t  req_a = '0;
  obi_req_t  req_b = '0;
  obi_req_t  req_c = '0;
  obi_resp_t resp_a, resp_b, resp_c;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  logic [31:0] mref [3][1024];
  exp_t        exp_q[$];
  stim_t       s[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gr_heep_obi_mem_slave #(.NUM_WORDS(1024), .GNT_WAIT(0), .RESP_LATENCY(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .slave_req_i(req_a), .slave_resp_o(resp_a));
  gr_heep_obi_mem_slave #(.NUM_WORDS(1024), .GNT_WAIT(3), .RESP_LATENCY(3)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .slave_req_i(req_b), .slave_resp_o(resp_b));
  gr_heep_obi_mem_slave #(.NUM_WORDS(16), .GNT_WAIT(0), .RESP_LATENCY(4)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .slave_req_i(req_c), .slave_resp_o(resp_c));

  function automatic int wait_of(input int d);
    return (d == 1) ? 3 : 0;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
  endfunction

  function automatic int depth_of(input int d);
    return (d == 2) ? 16 : 1024;
  endfunction

  function automatic obi_resp_t get_resp(input int d);
    if (d == 0) return resp_a;
    if (d == 1) return resp_b;
    return resp_c;
  endfunction

  function automatic void add(input int n, input logic req, input logic we, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] wdata);
    stim_t t;
    t.req = req; t.we = we; t.be = be; t.addr = addr; t.wdata = wdata;
    for (int i = 0; i < n; i++) s.push_back(t);
  endfunction

  // Reference: a granted transfer updates the word array and schedules its response.
  function automatic void issue(input int d, input stim_t t);
    int          idx;
    logic [31:0] rd;
    idx = int'((t.addr >> 2) % 32'(depth_of(d)));
    rd  = 32'h0;
    if (t.we) begin
      for (int k = 0; k < 4; k++)
        if (t.be[k]) mref[d][idx][8*k +: 8] = t.wdata[8*k +: 8];
    end else begin
      rd = mref[d][idx];
    end
    exp_q.push_back('{d: d, due: cyc + lat_of(d), data: rd});
  endfunction

  function automatic void exp_resp(input int d, output logic v, output logic [31:0] data);
    v    = 1'b0;
    data = 32'h0;
    if (exp_q.size() > 0 && exp_q[0].d == d && exp_q[0].due == cyc) begin
      v    = 1'b1;
      data = exp_q[0].data;
      void'(exp_q.pop_front());
    end
  endfunction

  task automatic drive(input int d, input stim_t t);
    obi_req_t r;
    r.req = t.req; r.we = t.we; r.be = t.be; r.addr = t.addr; r.wdata = t.wdata;
    @(posedge clk);
    #1;
    if (d == 0) req_a = r;
    else if (d == 1) req_b = r;
    else req_c = r;
    @(negedge clk);
  endtask

  task automatic test_reset();
    obi_resp_t r;
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        r = get_resp(d);
        checks++;
        if (r !== '0) begin
          errors++;
          $display("FAIL reset_outputs dut=%0d got gnt=%b rvalid=%b rdata=%h want all zero",
                   d, r.gnt, r.rvalid, r.rdata);
        end
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    obi_resp_t r; logic exp_g, ev; logic [31:0] ed;
    s.delete();
    add(1, 1, 1, 4'hF, 32'h10, 32'hDEADBEEF);
    add(1, 1, 0, 4'hF, 32'h10, 32'h0);
    add(3, 0, 0, 4'h0, 32'h0, 32'h0);
    foreach (s[i]) begin
      drive(0, s[i]);
      r = get_resp(0);
      exp_g = s[i].req;
      checks++;
      if (r.gnt !== exp_g) begin
        errors++; $display("FAIL basic_gnt cyc=%0d got %b want %b", cyc, r.gnt, exp_g);
      end
      exp_resp(0, ev, ed);
      checks++;
      if (r.rvalid !== ev || r.rdata !== ed) begin
        errors++;
        $display("FAIL basic_resp cyc=%0d got v=%b d=%h want v=%b d=%h", cyc, r.rvalid, r.rdata, ev, ed);
      end
      if (exp_g) issue(0, s[i]);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL basic_drain got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_byte_enables();
    obi_resp_t r; logic exp_g, ev; logic [31:0] ed;
    s.delete();
    add(1, 1, 1, 4'hF, 32'h14, 32'h11223344);
    add(1, 1, 1, 4'h5, 32'h14, 32'hAABBCCDD);
    add(1, 1, 0, 4'h0, 32'h14, 32'h0);
    add(1, 1, 1, 4'h0, 32'h14, 32'hFFFFFFFF);
    add(1, 1, 0, 4'h2, 32'h14, 32'h0);
    add(2, 0, 0, 4'h0, 32'h0, 32'h0);
    foreach (s[i]) begin
      drive(0, s[i]);
      r = get_resp(0);
      exp_g = s[i].req;
      checks++;
      if (r.gnt !== exp_g) begin
        errors++; $display("FAIL be_gnt cyc=%0d got %b want %b", cyc, r.gnt, exp_g);
      end
      exp_resp(0, ev, ed);
      checks++;
      if (r.rvalid !== ev || r.rdata !== ed) begin
        errors++;
        $display("FAIL be_resp cyc=%0d got v=%b d=%h want v=%b d=%h", cyc, r.rvalid, r.rdata, ev, ed);
      end
      if (exp_g) issue(0, s[i]);
    end
    checks++;
    if (mref[0][5] !== 32'h11BB33DD || exp_q.size() != 0) begin
      errors++;
      $display("FAIL be_final model word5=%h pending=%0d want 11bb33dd and 0", mref[0][5], exp_q.size());
    end
  endtask

  task automatic test_raw_hazard();
    obi_resp_t r; logic exp_g, ev; logic [31:0] ed;
    s.delete();
    add(1, 1, 1, 4'hF, 32'h24, 32'hCAFE0000);
    add(1, 1, 0, 4'hF, 32'h24, 32'h0);
    add(1, 1, 1, 4'hC, 32'h0010_1027, 32'h0000BEEF);
    add(1, 1, 0, 4'hF, 32'hFFF0_0024, 32'h0);
    add(2, 0, 0, 4'h0, 32'h0, 32'h0);
    foreach (s[i]) begin
      drive(0, s[i]);
      r = get_resp(0);
      exp_g = s[i].req;
      checks++;
      if (r.gnt !== exp_g) begin
        errors++; $display("FAIL raw_gnt cyc=%0d got %b want %b", cyc, r.gnt, exp_g);
      end
      exp_resp(0, ev, ed);
      checks++;
      if (r.rvalid !== ev || r.rdata !== ed) begin
        errors++;
        $display("FAIL raw_resp cyc=%0d got v=%b d=%h want v=%b d=%h", cyc, r.rvalid, r.rdata, ev, ed);
      end
      if (exp_g) issue(0, s[i]);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL raw_drain got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_random();
    obi_resp_t r; logic exp_g, ev; logic [31:0] ed; int w;
    s.delete();
    for (int i = 0; i < 16; i++) add(1, 1, 1, 4'hF, 32'(i * 4), $urandom);
    for (int i = 0; i < 80; i++) begin
      w = $urandom_range(0, 15);
      add(1, ($urandom_range(0, 9) < 7), 1'($urandom), 4'($urandom),
          ($urandom & 32'hFFFF_F000) | 32'(w << 2) | 32'($urandom_range(0, 3)), $urandom);
    end
    add(3, 0, 0, 4'h0, 32'h0, 32'h0);
    foreach (s[i]) begin
      drive(0, s[i]);
      r = get_resp(0);
      exp_g = s[i].req;
      checks++;
      if (r.gnt !== exp_g) begin
        errors++; $display("FAIL rand_gnt cyc=%0d got %b want %b", cyc, r.gnt, exp_g);
      end
      exp_resp(0, ev, ed);
      checks++;
      if (r.rvalid !== ev || r.rdata !== ed) begin
        errors++;
        $display("FAIL rand_resp cyc=%0d got v=%b d=%h want v=%b d=%h", cyc, r.rvalid, r.rdata, ev, ed);
      end
      if (exp_g) issue(0, s[i]);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rand_drain got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_pipeline();
    obi_resp_t r; logic exp_g, ev; logic [31:0] ed;
    s.delete();
    for (int i = 0; i < 8; i++) add(1, 1, 1, 4'hF, 32'(i * 4), 32'(i) * 32'h01010101);
    add(5, 0, 0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 8; i++) add(1, 1, 0, 4'hF, 32'(i * 4), 32'h0);
    add(1, 1, 0, 4'hF, 32'((16 + 3) * 4), 32'h0);
    add(6, 0, 0, 4'h0, 32'h0, 32'h0);
    foreach (s[i]) begin
      drive(2, s[i]);
      r = get_resp(2);
      exp_g = s[i].req;
      checks++;
      if (r.gnt !== exp_g) begin
        errors++; $display("FAIL pipe_gnt cyc=%0d got %b want %b", cyc, r.gnt, exp_g);
      end
      exp_resp(2, ev, ed);
      checks++;
      if (r.rvalid !== ev || r.rdata !== ed) begin
        errors++;
        $display("FAIL pipe_resp cyc=%0d got v=%b d=%h want v=%b d=%h", cyc, r.rvalid, r.rdata, ev, ed);
      end
      if (exp_g) issue(2, s[i]);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL pipe_drain got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_wait_states();
    obi_resp_t r; logic exp_g, ev; logic [31:0] ed; int held; int ngnt;
    s.delete();
    add(4, 1, 1, 4'hF, 32'h8, 32'h5A5A1234);
    add(4, 1, 0, 4'hF, 32'h8, 32'h0);
    add(2, 1, 1, 4'hF, 32'h40, 32'h00000001);
    add(1, 0, 0, 4'h0, 32'h0, 32'h0);
    add(4, 1, 0, 4'hF, 32'h40, 32'h0);
    add(4, 0, 0, 4'h0, 32'h0, 32'h0);
    held = 0;
    ngnt = 0;
    foreach (s[i]) begin
      drive(1, s[i]);
      r = get_resp(1);
      // Grant comes once req has been held, ungranted, for exactly GNT_WAIT cycles.
      exp_g = s[i].req && (held == wait_of(1));
      checks++;
      if (r.gnt !== exp_g) begin
        errors++; $display("FAIL wait_gnt step=%0d got %b want %b", i, r.gnt, exp_g);
      end
      exp_resp(1, ev, ed);
      checks++;
      if (r.rvalid !== ev || r.rdata !== ed) begin
        errors++;
        $display("FAIL wait_resp step=%0d got v=%b d=%h want v=%b d=%h", i, r.rvalid, r.rdata, ev, ed);
      end
      if (exp_g) begin
        issue(1, s[i]);
        ngnt++;
      end
      held = (s[i].req && !exp_g) ? held + 1 : 0;
    end
    checks++;
    if (exp_q.size() != 0 || ngnt != 3) begin
      errors++;
      $display("FAIL wait_drain got pending=%0d grants=%0d want 0 and 3", exp_q.size(), ngnt);
    end
  endtask

  task automatic test_reset_midflight();
    obi_resp_t r; logic exp_g, ev; logic [31:0] ed; int held;
    s.delete();
    add(4, 1, 0, 4'hF, 32'h8, 32'h0);
    held = 0;
    foreach (s[i]) begin
      drive(1, s[i]);
      r = get_resp(1);
      exp_g = s[i].req && (held == wait_of(1));
      checks++;
      if (r.gnt !== exp_g) begin
        errors++; $display("FAIL rstmf_pre_gnt step=%0d got %b want %b", i, r.gnt, exp_g);
      end
      if (exp_g) issue(1, s[i]);
      held = (s[i].req && !exp_g) ? held + 1 : 0;
    end
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_b.req = 1'b1;
    @(negedge clk);
    r = get_resp(1);
    checks++;
    if (r !== '0) begin
      errors++;
      $display("FAIL rstmf_in_reset got gnt=%b rvalid=%b rdata=%h want all zero", r.gnt, r.rvalid, r.rdata);
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_b = '0;
    s.delete();
    add(3, 0, 0, 4'h0, 32'h0, 32'h0);
    add(4, 1, 0, 4'hF, 32'h8, 32'h0);
    add(4, 0, 0, 4'h0, 32'h0, 32'h0);
    held = 0;
    foreach (s[i]) begin
      drive(1, s[i]);
      r = get_resp(1);
      exp_g = s[i].req && (held == wait_of(1));
      checks++;
      if (r.gnt !== exp_g) begin
        errors++; $display("FAIL rstmf_gnt step=%0d got %b want %b", i, r.gnt, exp_g);
      end
      exp_resp(1, ev, ed);
      checks++;
      if (r.rvalid !== ev || r.rdata !== ed) begin
        errors++;
        $display("FAIL rstmf_resp step=%0d got v=%b d=%h want v=%b d=%h", i, r.rvalid, r.rdata, ev, ed);
      end
      if (exp_g) issue(1, s[i]);
      held = (s[i].req && !exp_g) ? held + 1 : 0;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rstmf_drain got %0d pending want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_enables();
    test_raw_hazard();
    test_random();
    test_pipeline();
    test_wait_states();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
